// File: rtl/fifoctrl_level.sv
// FIFO controller: tracks read/write pointers and an explicit entry count for an
// external RAM. It supports a runtime depth (size_i), programmable almost-full and
// almost-empty thresholds, and sticky overflow/underflow error flags.
module fifoctrl_level #(
  parameter int unsigned AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [AW:0]   size_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  logic [AW:0]   af_thresh_i,
  input  logic [AW:0]   ae_thresh_i,
  output logic [AW-1:0] w_addr_o,
  output logic [AW-1:0] r_addr_o,
  output logic          we_o,
  output logic          re_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o,
  output logic          almost_empty_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam logic [AW:0] One = {{AW{1'b0}}, 1'b1};

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          full, empty;
  logic          we, re;
  logic [AW:0]   wptr_inc, rptr_inc;

  // Status decode from the registered count.
  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == size_i);
  end

  // Handshake: a pop needs data already stored, so a push into an empty FIFO cannot
  // feed a same-cycle pop. A push into a full FIFO is allowed only when a pop frees a slot.
  always_comb begin
    re = pop_i & ~empty & ~clear_i;
    we = push_i & ~clear_i & (~full | re);
  end

  // Pointer increment is one bit wider so that size_i == 2^AW still compares correctly.
  always_comb begin
    wptr_inc = {1'b0, wptr_q} + One;
    rptr_inc = {1'b0, rptr_q} + One;
  end

  // Next write/read pointer with wrap at the runtime depth.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (we) begin
        wptr_d = (wptr_inc == size_i) ? '0 : wptr_inc[AW-1:0];
      end
      if (re) begin
        rptr_d = (rptr_inc == size_i) ? '0 : rptr_inc[AW-1:0];
      end
    end
  end

  // Next entry count: simultaneous accepted push and pop leave it unchanged.
  always_comb begin
    level_d = level_q;
    if (clear_i) begin
      level_d = '0;
    end else if (we && !re) begin
      level_d = level_q + One;
    end else if (re && !we) begin
      level_d = level_q - One;
    end
  end

  // Sticky error flags, cleared only by a flush or reset.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clear_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (push_i && !we) begin
        ovf_d = 1'b1;
      end
      if (pop_i && !re) begin
        udf_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Output drive.
  always_comb begin
    w_addr_o       = wptr_q;
    r_addr_o       = rptr_q;
    we_o           = we;
    re_o           = re;
    level_o        = level_q;
    full_o         = full;
    empty_o        = empty;
    almost_full_o  = (level_q >= af_thresh_i);
    almost_empty_o = (level_q <= ae_thresh_i);
    overflow_o     = ovf_q;
    underflow_o    = udf_q;
  end

endmodule

// File: tb/tb_fifoctrl_level.sv
// Self-checking bench for fifoctrl_level: a directed vector table, hand-written
// sequences for reset, max-depth and threshold cases, and random traffic
// checked against a queue-based reference model.
module tb_fifoctrl_level;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic [AW:0]   size;
  logic          push, pop, clr;
  logic [AW:0]   af_th, ae_th;
  logic [AW-1:0] w_addr, r_addr;
  logic          we, re;
  logic [AW:0]   level;
  logic          full, empty, afull, aempty, ovf, udf;

  int total = 0;
  int bad   = 0;

  fifoctrl_level #(.AW(AW)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .size_i         (size),
    .push_i         (push),
    .pop_i          (pop),
    .clear_i        (clr),
    .af_thresh_i    (af_th),
    .ae_thresh_i    (ae_th),
    .w_addr_o       (w_addr),
    .r_addr_o       (r_addr),
    .we_o           (we),
    .re_o           (re),
    .level_o        (level),
    .full_o         (full),
    .empty_o        (empty),
    .almost_full_o  (afull),
    .almost_empty_o (aempty),
    .overflow_o     (ovf),
    .underflow_o    (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Check all registered-state outputs against expected values.
  task automatic chk_state(input string tag, input int lvl, input int wa, input int ra,
                           input int eo, input int eu, input int sz, input int aft,
                           input int aet);
    chk({tag, ".level"}, int'(level), lvl);
    chk({tag, ".w_addr"}, int'(w_addr), wa);
    chk({tag, ".r_addr"}, int'(r_addr), ra);
    chk({tag, ".overflow"}, int'(ovf), eo);
    chk({tag, ".underflow"}, int'(udf), eu);
    chk({tag, ".full"}, int'(full), int'(lvl == sz));
    chk({tag, ".empty"}, int'(empty), int'(lvl == 0));
    chk({tag, ".afull"}, int'(afull), int'(lvl >= aft));
    chk({tag, ".aempty"}, int'(aempty), int'(lvl <= aet));
  endtask

  // One clock: drive at posedge+1, leave the inputs for the edge, return at posedge+1.
  task automatic cyc(input bit pu, input bit po, input bit cl);
    push = pu;
    pop  = po;
    clr  = cl;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit pu, po, cl;
    bit we, re;
    int lvl, wa, ra;
    bit ovf, udf;
  } vec_t;

  function automatic vec_t mk(input bit pu, input bit po, input bit cl, input bit e_we,
                              input bit e_re, input int lvl, input int wa, input int ra,
                              input bit e_ovf, input bit e_udf);
    vec_t v;
    v.pu = pu; v.po = po; v.cl = cl; v.we = e_we; v.re = e_re;
    v.lvl = lvl; v.wa = wa; v.ra = ra; v.ovf = e_ovf; v.udf = e_udf;
    return v;
  endfunction

  vec_t vecs[21];

  // Reference model state for random traffic.
  int q[$];
  int m_sz, m_wp, m_ovf, m_udf;

  initial begin
    // Directed table, size 5, af=4, ae=1. Fields: inputs, we/re this cycle, state after edge.
    for (int i = 0; i < 5; i++) vecs[i] = mk(1, 0, 0, 1, 0, i + 1, (i + 1) % 5, 0, 0, 0);
    vecs[5] = mk(1, 0, 0, 0, 0, 5, 0, 0, 1, 0);              // push to full rejected
    for (int i = 6; i < 11; i++) vecs[i] = mk(0, 1, 0, 0, 1, 10 - i, 0, (i - 5) % 5, 1, 0);
    vecs[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1);             // pop from empty rejected
    vecs[12] = mk(1, 1, 0, 1, 0, 1, 1, 0, 1, 1);             // push+pop at empty: no fall-through
    vecs[13] = mk(1, 0, 0, 1, 0, 2, 2, 0, 1, 1);
    vecs[14] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);             // clear ignores push
    for (int i = 15; i < 20; i++) vecs[i] = mk(1, 0, 0, 1, 0, i - 14, (i - 14) % 5, 0, 0, 0);
    vecs[20] = mk(1, 1, 0, 1, 1, 5, 1, 1, 0, 0);             // push+pop at full

    rst_n = 1'b0;
    push = 0; pop = 0; clr = 0;
    size = 5'd5; af_th = 5'd4; ae_th = 5'd1;
    #1;
    chk_state("por", 0, 0, 0, 0, 0, 5, 4, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      push = vecs[i].pu; pop = vecs[i].po; clr = vecs[i].cl;
      #1;
      chk($sformatf("vec%0d.we", i), int'(we), int'(vecs[i].we));
      chk($sformatf("vec%0d.re", i), int'(re), int'(vecs[i].re));
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].wa, vecs[i].ra,
                int'(vecs[i].ovf), int'(vecs[i].udf), 5, 4, 1);
    end

    // Asynchronous reset at level 3 with overflow set.
    cyc(1, 0, 0);                        // rejected push at full -> overflow
    cyc(0, 1, 0);
    cyc(0, 1, 0);                        // level 3, w=1, r=3
    chk_state("prerst", 3, 1, 3, 1, 0, 5, 4, 1);
    push = 0; pop = 0; clr = 0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_state("asyncrst", 0, 0, 0, 0, 0, 5, 4, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 0, 0);
    chk_state("postrst", 1, 1, 0, 0, 0, 5, 4, 1);

    // Max depth 16 with thresholds af=4, ae=1.
    cyc(0, 0, 1);
    size = 5'd16;
    #1;
    chk_state("max0", 0, 0, 0, 0, 0, 16, 4, 1);
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 0, 0);
      chk_state($sformatf("max%0d", k), k, k % 16, 0, 0, 0, 16, 4, 1);
    end
    for (int k = 15; k >= 0; k--) begin
      cyc(0, 1, 0);
      chk_state($sformatf("maxpop%0d", k), k, 0, (16 - k) % 16, 0, 0, 16, 4, 1);
    end

    // Random traffic against a queue model.
    cyc(0, 0, 1);
    m_sz = 16; m_wp = 0; m_ovf = 0; m_udf = 0;
    q.delete();
    for (int n = 0; n < 1500; n++) begin
      int e_re, e_we;
      bit pu, po, cl;
      if (n % 250 == 249) begin
        // Flush, then pick a new depth and thresholds while empty.
        cyc(0, 0, 1);
        q.delete(); m_wp = 0; m_ovf = 0; m_udf = 0;
        m_sz  = $urandom_range(1, 16);
        size  = 5'(m_sz);
        af_th = 5'($urandom_range(0, 17));
        ae_th = 5'($urandom_range(0, 17));
        #1;
        chk_state("rndflush", 0, 0, 0, 0, 0, m_sz, int'(af_th), int'(ae_th));
        continue;
      end
      // Bias traffic toward filling or draining in alternating phases.
      if ((n / 60) % 2 == 0) begin
        pu = ($urandom_range(0, 3) != 0);
        po = ($urandom_range(0, 3) == 0);
      end else begin
        pu = ($urandom_range(0, 3) == 0);
        po = ($urandom_range(0, 3) != 0);
      end
      cl = ($urandom_range(0, 99) == 0);
      push = pu; pop = po; clr = cl;
      #1;
      e_re = int'(po && !cl && q.size() > 0);
      e_we = int'(pu && !cl && (q.size() < m_sz || e_re != 0));
      chk("rnd.we", int'(we), e_we);
      chk("rnd.re", int'(re), e_re);
      @(posedge clk);
      #1;
      if (cl) begin
        q.delete(); m_wp = 0; m_ovf = 0; m_udf = 0;
      end else begin
        if (pu && e_we == 0) m_ovf = 1;
        if (po && e_re == 0) m_udf = 1;
        if (e_re != 0) void'(q.pop_front());
        if (e_we != 0) begin
          q.push_back(m_wp);             // remember where each entry was written
          m_wp = (m_wp + 1) % m_sz;
        end
      end
      chk_state("rnd", q.size(), m_wp, (q.size() > 0) ? q[0] : m_wp, m_ovf, m_udf,
                m_sz, int'(af_th), int'(ae_th));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
